// File: rtl/mem_cmd_sequencer.sv
// mem_cmd_sequencer: splits word-granular memory commands into fixed-size DDR
// bursts on a MIG-style native app interface. Write words are packed into
// masked bursts. Read bursts land in a credit-limited return buffer and are
// unpacked back into a word stream.
// Optional build macro: MEM_CMD_SEQ_STATS_EN adds stat_cmds, stat_wr_bursts
// and stat_rd_bursts free-running counters.
module mem_cmd_sequencer #(
  parameter int unsigned mem_width     = 32,
  parameter int unsigned burst_words   = 4,
  parameter int unsigned addr_width    = 28,
  parameter int unsigned rd_buf_bursts = 4
) (
  input  logic                                clk_mem,
  input  logic                                reset,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [64:0]                         cmd_data,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [mem_width-1:0]                wr_data,
  output logic                                rd_valid,
  input  logic                                rd_ready,
  output logic [mem_width-1:0]                rd_data,
  output logic                                app_en,
  input  logic                                app_rdy,
  output logic [2:0]                          app_cmd,
  output logic [addr_width-1:0]               app_addr,
  output logic                                app_wdf_wren,
  output logic                                app_wdf_end,
  input  logic                                app_wdf_rdy,
  output logic [mem_width*burst_words-1:0]    app_wdf_data,
  output logic [mem_width/8*burst_words-1:0]  app_wdf_mask,
  input  logic [mem_width*burst_words-1:0]    app_rd_data,
  input  logic                                app_rd_data_valid,
  output logic                                busy
`ifdef MEM_CMD_SEQ_STATS_EN
  ,
  output logic [31:0]                         stat_cmds,
  output logic [31:0]                         stat_wr_bursts,
  output logic [31:0]                         stat_rd_bursts
`endif
);

  localparam int unsigned BYTES      = mem_width / 8;
  localparam int unsigned SW         = $clog2(burst_words);
  localparam int unsigned PW         = $clog2(rd_buf_bursts);
  localparam int unsigned CW         = PW + 1;
  localparam int unsigned BURST_BITS = mem_width * burst_words;
  localparam int unsigned MASK_BITS  = BYTES * burst_words;

  typedef enum logic [2:0] {IDLE, WR_FILL, WR_DATA, WR_CMD, RD_CMD} state_t;

  state_t state, state_next;

  logic [31:0]           addr, remaining, burst_base;
  logic [CW-1:0]         credits;
  logic [SW-1:0]         slot;
  logic [BURST_BITS-1:0] wdata;
  logic [MASK_BITS-1:0]  wmask;

  // Read return buffer: data and metadata share one read pointer because the
  // head of both always describes the oldest unretired burst.
  logic [BURST_BITS-1:0] rbuf       [rd_buf_bursts];
  logic [SW-1:0]         meta_first [rd_buf_bursts];
  logic [SW-1:0]         meta_last  [rd_buf_bursts];
  logic [PW-1:0]         mwptr, bwptr, rptr;
  logic [CW-1:0]         dcount;
  logic [SW-1:0]         rd_off, cur_slot;

  logic        cmd_rnw;
  logic [31:0] cmd_addr, cmd_len;
  logic        cmd_fire, wr_fire, app_fire, rd_issue, rd_fire, retire;
  logic [31:0] rd_avail, rd_take;
  logic        rd_last_burst;
  logic [SW-1:0] rd_last_slot;

  assign cmd_rnw  = cmd_data[64];
  assign cmd_addr = cmd_data[63:32];
  assign cmd_len  = cmd_data[31:0];
  assign slot     = addr[SW-1:0];

  assign cmd_fire = cmd_valid && cmd_ready;
  assign wr_fire  = wr_valid && wr_ready;
  assign app_fire = app_en && app_rdy;
  assign rd_issue = app_fire && (state == RD_CMD);
  assign rd_fire  = rd_valid && rd_ready;
  assign cur_slot = meta_first[rptr] + rd_off;
  assign retire   = rd_fire && (cur_slot == meta_last[rptr]);

  // Size of the read burst about to be issued: up to the end of the burst or
  // the end of the command, whichever comes first.
  always_comb begin
    rd_avail      = 32'(burst_words) - 32'(slot);
    rd_last_burst = (remaining <= rd_avail);
    rd_take       = rd_last_burst ? remaining : rd_avail;
    rd_last_slot  = SW'(32'(slot) + rd_take - 32'd1);
  end

  // Moore-style outputs decoded from the state and datapath registers.
  assign cmd_ready    = (state == IDLE);
  assign wr_ready     = (state == WR_FILL);
  assign app_wdf_wren = (state == WR_DATA);
  assign app_wdf_end  = (state == WR_DATA);
  assign app_en       = (state == WR_CMD) || ((state == RD_CMD) && (credits != '0));
  assign app_cmd      = (state == RD_CMD) ? 3'b001 : 3'b000;
  assign app_addr     = addr_width'(burst_base * BYTES);
  assign app_wdf_data = wdata;
  assign app_wdf_mask = wmask;
  assign rd_valid     = (dcount != '0);
  assign rd_data      = rbuf[rptr][cur_slot*mem_width +: mem_width];
  assign busy         = (state != IDLE) || (credits != CW'(rd_buf_bursts));

  // State register.
  always_ff @(posedge clk_mem or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire && (cmd_len != '0)) state_next = cmd_rnw ? RD_CMD : WR_FILL;
      WR_FILL: if (wr_fire && ((&slot) || (remaining == 32'd1))) state_next = WR_DATA;
      WR_DATA: if (app_wdf_rdy) state_next = WR_CMD;
      WR_CMD:  if (app_rdy) state_next = (remaining != '0) ? WR_FILL : IDLE;
      RD_CMD:  if (rd_issue && rd_last_burst) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command datapath: address walk, remaining length, write burst packing.
  always_ff @(posedge clk_mem or negedge reset) begin
    if (!reset) begin
      addr       <= '0;
      remaining  <= '0;
      burst_base <= '0;
      wdata      <= '0;
      wmask      <= '1;
    end else begin
      case (state)
        IDLE: if (cmd_fire && (cmd_len != '0)) begin
          addr       <= cmd_addr;
          remaining  <= cmd_len;
          burst_base <= cmd_addr & ~32'(burst_words - 1);
        end
        WR_FILL: if (wr_fire) begin
          wdata[slot*mem_width +: mem_width] <= wr_data;
          wmask[slot*BYTES +: BYTES]         <= '0;
          addr      <= addr + 32'd1;
          remaining <= remaining - 32'd1;
        end
        WR_CMD: if (app_rdy) begin
          burst_base <= burst_base + 32'(burst_words);
          wmask      <= '1;
        end
        RD_CMD: if (rd_issue) begin
          addr       <= addr + rd_take;
          remaining  <= remaining - rd_take;
          burst_base <= burst_base + 32'(burst_words);
        end
        default: ;
      endcase
    end
  end

  // Read credits: one per buffer slot, held from issue until retire.
  always_ff @(posedge clk_mem or negedge reset) begin
    if (!reset) credits <= CW'(rd_buf_bursts);
    else begin
      case ({rd_issue, retire})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: ;
      endcase
    end
  end

  // Metadata push on issue, burst capture on return, word unpack on drain.
  always_ff @(posedge clk_mem or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < rd_buf_bursts; i++) begin
        rbuf[PW'(i)]       <= '0;
        meta_first[PW'(i)] <= '0;
        meta_last[PW'(i)]  <= '0;
      end
      mwptr  <= '0;
      bwptr  <= '0;
      rptr   <= '0;
      dcount <= '0;
      rd_off <= '0;
    end else begin
      if (rd_issue) begin
        meta_first[mwptr] <= slot;
        meta_last[mwptr]  <= rd_last_slot;
        mwptr             <= mwptr + PW'(1);
      end
      if (app_rd_data_valid) begin
        rbuf[bwptr] <= app_rd_data;
        bwptr       <= bwptr + PW'(1);
      end
      if (rd_fire) begin
        if (retire) begin
          rptr   <= rptr + PW'(1);
          rd_off <= '0;
        end else begin
          rd_off <= rd_off + SW'(1);
        end
      end
      case ({app_rd_data_valid, retire})
        2'b10:   dcount <= dcount + CW'(1);
        2'b01:   dcount <= dcount - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef MEM_CMD_SEQ_STATS_EN
  // Free-running activity counters.
  always_ff @(posedge clk_mem or negedge reset) begin
    if (!reset) begin
      stat_cmds      <= '0;
      stat_wr_bursts <= '0;
      stat_rd_bursts <= '0;
    end else begin
      if (cmd_fire)                     stat_cmds      <= stat_cmds + 32'd1;
      if (app_fire && state == WR_CMD)  stat_wr_bursts <= stat_wr_bursts + 32'd1;
      if (rd_issue)                     stat_rd_bursts <= stat_rd_bursts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Scoreboard bench for mem_cmd_sequencer: stimulus pushes expected app
// commands, write bursts and read words; a negedge monitor pops and compares
// on every handshake. A small memory model answers read bursts.
module tb_mem_cmd_sequencer;

  logic         clk_mem = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [64:0]  cmd_data = '0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [31:0]  wr_data = '0;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [31:0]  rd_data;
  logic         app_en;
  logic         app_rdy = 1'b0;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;
  logic         app_wdf_wren, app_wdf_end;
  logic         app_wdf_rdy = 1'b0;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic [127:0] app_rd_data = '0;
  logic         app_rd_data_valid = 1'b0;
  logic         busy;

  mem_cmd_sequencer #(.mem_width(32), .burst_words(4), .addr_width(28), .rd_buf_bursts(4)) dut (
    .clk_mem(clk_mem), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .app_en(app_en), .app_rdy(app_rdy), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .busy(busy)
  );

  always #5 clk_mem = ~clk_mem;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  mask;
  } wdf_t;

  wdf_t        exp_wdf[$];
  logic [30:0] exp_app[$];
  logic [31:0] exp_rd[$];
  logic [27:0] mem_pend[$];

  int checks = 0;
  int passes = 0;
  int rd_issue_cnt = 0;
  int app_cnt = 0;
  bit wdf_block = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: event not expected or timed out", name);
  endtask

  // Ready stimulus and memory model, updated just after each rising edge.
  always @(posedge clk_mem) begin : drv
    logic [27:0] a;
    #1;
    app_rdy           = ($urandom_range(0, 3) != 0);
    app_wdf_rdy       = wdf_block ? 1'b0 : ($urandom_range(0, 3) != 0);
    app_rd_data_valid = 1'b0;
    if (reset && mem_pend.size() > 0 && $urandom_range(0, 2) != 0) begin
      a = mem_pend.pop_front();
      for (int i = 0; i < 4; i++)
        app_rd_data[i*32 +: 32] = 32'hD000_0000 + 32'(a >> 2) + 32'(i);
      app_rd_data_valid = 1'b1;
    end
  end

  // Monitor: compare every handshake against the scoreboard queues.
  always @(negedge clk_mem) begin : mon
    wdf_t         e;
    logic [30:0]  ca;
    logic [127:0] keep;
    logic [31:0]  w;
    if (reset) begin
      if (app_en && app_rdy) begin
        app_cnt++;
        if (app_cmd == 3'b001) begin
          rd_issue_cnt++;
          mem_pend.push_back(app_addr);
        end
        if (exp_app.size() == 0) fail("app_unexpected");
        else begin
          ca = exp_app.pop_front();
          check("app_cmd", 128'(app_cmd), 128'(ca[30:28]));
          check("app_addr", 128'(app_addr), 128'(ca[27:0]));
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        if (exp_wdf.size() == 0) fail("wdf_unexpected");
        else begin
          e = exp_wdf.pop_front();
          for (int b = 0; b < 16; b++) keep[b*8 +: 8] = e.mask[b] ? 8'h00 : 8'hFF;
          check("wdf_end", 128'(app_wdf_end), 128'(app_wdf_wren));
          check("wdf_mask", 128'(app_wdf_mask), 128'(e.mask));
          check("wdf_data", app_wdf_data & keep, e.data & keep);
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) fail("rd_unexpected");
        else begin
          w = exp_rd.pop_front();
          check("rd_data", 128'(rd_data), 128'(w));
        end
      end
    end
  end

  task automatic send_cmd(input logic rnw, input logic [31:0] a, input logic [31:0] len);
    bit done = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = {rnw, a, len};
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk_mem);
      if (cmd_ready) done = 1'b1;
    end
    if (!done) fail("cmd_timeout");
    @(posedge clk_mem); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    bit done = 1'b0;
    wr_valid = 1'b1;
    wr_data  = d;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk_mem);
      if (wr_ready) done = 1'b1;
    end
    if (!done) fail("wr_timeout");
    @(posedge clk_mem); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk_mem);
      if (!busy && exp_app.size() == 0 && exp_wdf.size() == 0 &&
          exp_rd.size() == 0 && mem_pend.size() == 0) done = 1'b1;
    end
    if (!done) fail("idle_timeout");
    @(posedge clk_mem); #1;
  endtask

  initial begin
    int base;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk_mem);
    #1;
    check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    check("rst_app_en", 128'(app_en), 128'(0));
    check("rst_wr_ready", 128'(wr_ready), 128'(0));
    check("rst_rd_valid", 128'(rd_valid), 128'(0));
    check("rst_wdf_wren", 128'(app_wdf_wren), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_mask", 128'(app_wdf_mask), 128'(16'hFFFF));
    check("rst_app_addr", 128'(app_addr), 128'(0));
    check("rst_rd_data", 128'(rd_data), 128'(0));
    @(posedge clk_mem); #1;
    reset = 1'b1;

    // Aligned write: addr 0x10, len 4
    exp_wdf.push_back('{data: {32'hA3, 32'hA2, 32'hA1, 32'hA0}, mask: 16'h0000});
    exp_app.push_back({3'b000, 28'h40});
    send_cmd(1'b0, 32'h10, 32'd4);
    for (int i = 0; i < 4; i++) send_word(32'hA0 + 32'(i));
    wait_idle();

    // Unaligned write: addr 0x5, len 5 -> two partial bursts
    exp_wdf.push_back('{data: {32'hB2, 32'hB1, 32'hB0, 32'h0}, mask: 16'h000F});
    exp_app.push_back({3'b000, 28'h10});
    exp_wdf.push_back('{data: {32'h0, 32'h0, 32'hB4, 32'hB3}, mask: 16'hFF00});
    exp_app.push_back({3'b000, 28'h20});
    send_cmd(1'b0, 32'h5, 32'd5);
    for (int i = 0; i < 5; i++) send_word(32'hB0 + 32'(i));
    wait_idle();

    // Read addr 0x2, len 6 -> bursts 0x00 and 0x10, words 2..7
    rd_ready = 1'b1;
    exp_app.push_back({3'b001, 28'h00});
    exp_app.push_back({3'b001, 28'h10});
    for (int i = 2; i < 8; i++) exp_rd.push_back(32'hD000_0000 + 32'(i));
    send_cmd(1'b1, 32'h2, 32'd6);
    wait_idle();

    // Read len 32 with rd_ready low: credits stop issue at 4 bursts
    rd_ready = 1'b0;
    base = rd_issue_cnt;
    for (int k = 0; k < 8; k++) exp_app.push_back({3'b001, 28'h400 + 28'(k * 16)});
    for (int i = 0; i < 32; i++) exp_rd.push_back(32'hD000_0100 + 32'(i));
    send_cmd(1'b1, 32'h100, 32'd32);
    repeat (40) @(posedge clk_mem);
    #1;
    check("stall_issues", 128'(rd_issue_cnt - base), 128'(4));
    check("stall_busy", 128'(busy), 128'(1));
    rd_ready = 1'b1;
    wait_idle();

    // Zero-length write and read: accepted, no app activity
    base = app_cnt;
    send_cmd(1'b0, 32'h20, 32'd0);
    send_cmd(1'b1, 32'h30, 32'd0);
    @(negedge clk_mem);
    check("len0_busy", 128'(busy), 128'(0));
    repeat (5) @(posedge clk_mem);
    #1;
    check("len0_no_app", 128'(app_cnt), 128'(base));

    // Reset while stuck in WR_DATA
    wdf_block = 1'b1;
    send_cmd(1'b0, 32'h0, 32'd1);
    send_word(32'h1234);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_mem);
      if (app_wdf_wren) seen = 1'b1;
    end
    if (!seen) fail("wdf_wait_timeout");
    reset = 1'b0;
    #1;
    check("rstmid_wdf_wren", 128'(app_wdf_wren), 128'(0));
    check("rstmid_app_en", 128'(app_en), 128'(0));
    check("rstmid_busy", 128'(busy), 128'(0));
    check("rstmid_mask", 128'(app_wdf_mask), 128'(16'hFFFF));
    @(posedge clk_mem); #1;
    reset = 1'b1;
    wdf_block = 1'b0;
    @(negedge clk_mem);
    check("rstmid_cmd_ready", 128'(cmd_ready), 128'(1));

    // Drained scoreboards
    repeat (5) @(posedge clk_mem);
    check("exp_app_left", 128'(exp_app.size()), 128'(0));
    check("exp_rd_left", 128'(exp_rd.size()), 128'(0));
    check("exp_wdf_left", 128'(exp_wdf.size()), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
